alu_op_issue: RTL

- Upstream issue stage that feeds the ALU.
- Accepts complete operation requests (cmd, mode, cin, opa, opb) on a valid/ready stream and buffers them in a small FIFO.
- Drives the ALU input bus (ce, mode, cin, cmd, inp_valid, opa, opb) one operation at a time. Inter-issue gaps respect ALU latency: longer for multiply commands.
- Optionally splits an operation into separate opa-then-opb issues, to exercise the ALU's 16-cycle operand-wait path.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_req_fifo.sv | 58 +++++
 rtl/alu_op_issue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, command codes, issue FSM states and request record
package alu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int CMD_WIDTH  = 4;

    localparam logic [CMD_WIDTH-1:0] CMD_MUL_INC = 4'd9;
    localparam logic [CMD_WIDTH-1:0] CMD_MUL_SHL = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_BOTH,
        ST_ISSUE_A,
        ST_SPLIT_WAIT,
        ST_ISSUE_B,
        ST_GAP_WAIT
    } issue_state_t;

    typedef struct packed {
        logic [CMD_WIDTH-1:0]  cmd;
        logic                  mode;
        logic                  cin;
        logic [DATA_WIDTH-1:0] opa;
        logic [DATA_WIDTH-1:0] opb;
        logic                  split;
    } alu_req_t;

    // Multiplies only exist in arithmetic mode; they need the longer ALU settle gap.
    function automatic logic is_mul(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - show-ahead synchronous FIFO of ALU requests
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  alu_req_t wdata,
    output alu_req_t rdata,
    output logic     full,
    output logic     empty,
    output logic [AW:0] count
);

    alu_req_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - buffers ALU requests and issues them with latency-aware gaps
module alu_op_issue #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int DEPTH      = 4,
    parameter int GAP        = 1,
    parameter int MUL_GAP    = 2,
    parameter int SPLIT_DLY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CMD_WIDTH-1:0]  req_cmd,
    input  logic                  req_mode,
    input  logic                  req_cin,
    input  logic [DATA_WIDTH-1:0] req_opa,
    input  logic [DATA_WIDTH-1:0] req_opb,
    input  logic                  req_split,
    output logic                  ce,
    output logic                  mode,
    output logic                  cin,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic [1:0]            inp_valid,
    output logic [DATA_WIDTH-1:0] opa,
    output logic [DATA_WIDTH-1:0] opb,
    output logic                  busy,
    output logic [15:0]           issue_cnt
);

    import alu_pkg::*;

    localparam int CW          = $clog2(DEPTH) + 1;
    localparam int GAP_EFF     = (GAP < 1) ? 1 : GAP;
    localparam int MUL_GAP_EFF = (MUL_GAP < 1) ? 1 : MUL_GAP;
    localparam logic [3:0] GAP_LOAD     = 4'(GAP_EFF - 1);
    localparam logic [3:0] MUL_GAP_LOAD = 4'(MUL_GAP_EFF - 1);
    localparam logic [3:0] SPLIT_LOAD   = 4'((SPLIT_DLY < 2) ? 0 : SPLIT_DLY - 2);

    alu_req_t              fifo_wdata;
    alu_req_t              fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_count;
    issue_state_t          state;
    logic [3:0]            gap_cnt;
    logic [3:0]            split_cnt;
    logic                  cur_mul;
    logic [DATA_WIDTH-1:0] cur_opb;
    logic                  issue_slot;

    assign fifo_wdata = '{cmd: req_cmd, mode: req_mode, cin: req_cin,
                          opa: req_opa, opb: req_opb, split: req_split};

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign req_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    // The last gap cycle doubles as an issue slot so queued ops run without an IDLE bubble.
    assign issue_slot = (state == ST_IDLE) || ((state == ST_GAP_WAIT) && (gap_cnt == 4'd0));
    assign fifo_pop   = issue_slot && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            split_cnt <= '0;
            cur_mul   <= 1'b0;
            cur_opb   <= '0;
            issue_cnt <= '0;
            ce        <= 1'b0;
            mode      <= 1'b0;
            cin       <= 1'b0;
            cmd       <= '0;
            inp_valid <= 2'b00;
            opa       <= '0;
            opb       <= '0;
        end else begin
            case (state)
                ST_ISSUE_BOTH, ST_ISSUE_B: begin
                    state     <= ST_GAP_WAIT;
                    inp_valid <= 2'b00;
                    gap_cnt   <= cur_mul ? MUL_GAP_LOAD : GAP_LOAD;
                    issue_cnt <= issue_cnt + 1'b1;
                end
                ST_ISSUE_A: begin
                    if (SPLIT_DLY <= 1) begin
                        state     <= ST_ISSUE_B;
                        inp_valid <= 2'b10;
                        opb       <= cur_opb;
                    end else begin
                        state     <= ST_SPLIT_WAIT;
                        inp_valid <= 2'b00;
                        split_cnt <= SPLIT_LOAD;
                    end
                end
                ST_SPLIT_WAIT: begin
                    if (split_cnt == 4'd0) begin
                        state     <= ST_ISSUE_B;
                        inp_valid <= 2'b10;
                        opb       <= cur_opb;
                    end else begin
                        split_cnt <= split_cnt - 1'b1;
                    end
                end
                ST_GAP_WAIT: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (fifo_empty) begin
                        state <= ST_IDLE;
                        ce    <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    ce <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    ce    <= 1'b0;
                end
            endcase

            // A pop overrides the state-specific updates above with the new op's first beat.
            if (fifo_pop) begin
                ce      <= 1'b1;
                mode    <= fifo_rdata.mode;
                cin     <= fifo_rdata.cin;
                cmd     <= fifo_rdata.cmd;
                opa     <= fifo_rdata.opa;
                cur_opb <= fifo_rdata.opb;
                cur_mul <= is_mul(fifo_rdata.mode, fifo_rdata.cmd);
                if (fifo_rdata.split) begin
                    state     <= ST_ISSUE_A;
                    inp_valid <= 2'b01;
                    opb       <= '0;
                end else begin
                    state     <= ST_ISSUE_BOTH;
                    inp_valid <= 2'b11;
                    opb       <= fifo_rdata.opb;
                end
            end
        end
    end

endmodule
